// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run/step sequencer.
package proc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } ctrl_state_t;

   localparam int PC_W        = 7;
   localparam int DIV_DEFAULT = 25_000_000;

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-DIV counter; Tick marks the cycle the count sits at DIV-1.
module rate_divider #(
   parameter int DIV = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Clr,
   input  logic En,
   output logic Tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Count while enabled, wrapping from DIV-1 back to zero.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count <= '0;
      end else if (Clr) begin
         count <= '0;
      end else if (En) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end else begin
         count <= count;
      end
   end

   assign Tick = (count == LAST);

endmodule

// File: rtl/proc_run_controller.sv
// Run/step sequencer producing the processor advance enable ProcEn.
// Define PROC_RUN_STEP_COUNT_EN to enable the ProcEn pulse counter on StepCount.
module proc_run_controller
   import proc_ctrl_pkg::*;
#(
   parameter int DIV  = DIV_DEFAULT,
   parameter int PC_W = proc_ctrl_pkg::PC_W
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            StepStrobe,
   input  logic            Run,
   input  logic            BrkEn,
   input  logic [PC_W-1:0] BrkAddr,
   input  logic [PC_W-1:0] PC,
   output logic            ProcEn,
   output logic            Running,
   output logic            Halted,
   output logic [1:0]      Mode,
   output logic [15:0]     StepCount
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   logic        skip;
   logic        skip_nxt;
   logic        pulse_nxt;
   logic        tick;
   logic        brk_hit;

   rate_divider #(.DIV(DIV)) u_div (
      .Clock (Clock),
      .Reset (Reset),
      .Clr   ((state != RUN) || !Run),
      .En    (state == RUN),
      .Tick  (tick)
   );

   // Skip lets the first pulse after leaving HALT move past the breakpoint.
   assign brk_hit = BrkEn && (PC == BrkAddr) && !skip;

   // Next-state, run-pulse and skip-flag decisions.
   always_comb begin
      state_nxt = state;
      skip_nxt  = skip;
      pulse_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (Run) begin
               state_nxt = RUN;
            end else if (StepStrobe) begin
               state_nxt = STEP;
            end else begin
               state_nxt = IDLE;
            end
         end
         STEP: begin
            state_nxt = IDLE;
         end
         RUN: begin
            if (!Run) begin
               state_nxt = IDLE;
            end else if (tick && brk_hit) begin
               state_nxt = HALT;
            end else if (tick) begin
               pulse_nxt = 1'b1;
               skip_nxt  = 1'b0;
            end else begin
               state_nxt = RUN;
            end
         end
         HALT: begin
            if (StepStrobe) begin
               state_nxt = STEP;
               skip_nxt  = 1'b1;
            end else if (!Run) begin
               state_nxt = IDLE;
               skip_nxt  = 1'b1;
            end else begin
               state_nxt = HALT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, skip flag and all registered outputs.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state   <= IDLE;
         skip    <= 1'b0;
         ProcEn  <= 1'b0;
         Running <= 1'b0;
         Halted  <= 1'b0;
      end else begin
         state   <= state_nxt;
         skip    <= skip_nxt;
         ProcEn  <= pulse_nxt || (state_nxt == STEP);
         Running <= (state_nxt == RUN);
         Halted  <= (state_nxt == HALT);
      end
   end

   assign Mode = state;

`ifdef PROC_RUN_STEP_COUNT_EN
   logic [15:0] step_count;

   // Counts every advance pulse; wraps naturally at 16 bits.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         step_count <= 16'h0000;
      end else if (ProcEn) begin
         step_count <= step_count + 16'd1;
      end else begin
         step_count <= step_count;
      end
   end

   assign StepCount = step_count;
`else
   assign StepCount = 16'h0000;
`endif

endmodule
